// File: rtl/player_input_ctrl.sv
// player_input_ctrl: turns debounced Hit/Stay button events into single HIT, STAY
// or RESTART commands that are held until the game FSM acknowledges them.
`default_nettype none

module player_input_ctrl #(
   parameter int HOLD_CYCLES    = 2000,
   parameter int LOCKOUT_CYCLES = 100
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_HitDeb,
   input  logic i_HitDown,
   input  logic i_StayDeb,
   input  logic i_StayDown,
   input  logic i_CmdAck,
   output logic o_CmdValid,
   output logic o_CmdHit,
   output logic o_CmdStay,
   output logic o_CmdRestart,
   output logic o_Busy
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_STAY = 2'd1,
      PENDING   = 2'd2,
      LOCKOUT   = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lock_next;
   logic             cmd_hit;
   logic             cmd_stay;
   logic             cmd_restart;

   // Lockout exit is judged on the value the counter is about to take, so the
   // FSM is back in IDLE in time to accept a press on edge ack+LOCKOUT_CYCLES.
   assign lock_next = (cnt == LOCK_LAST) ? cnt : cnt + CNT_ONE;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state       <= IDLE;
         cnt         <= '0;
         cmd_hit     <= 1'b0;
         cmd_stay    <= 1'b0;
         cmd_restart <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_HitDown && !i_StayDown) begin
                  cmd_hit <= 1'b1;
                  state   <= PENDING;
               end else if (i_StayDown && !i_HitDown) begin
                  cnt   <= '0;
                  state <= HOLD_STAY;
               end
            end
            HOLD_STAY: begin
               // Release takes priority over reaching the hold limit.
               if (i_StayDeb) begin
                  cmd_stay <= 1'b1;
                  state    <= PENDING;
               end else if (cnt == HOLD_LAST) begin
                  cmd_restart <= 1'b1;
                  state       <= PENDING;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PENDING: begin
               if (i_CmdAck) begin
                  cnt         <= '0;
                  cmd_hit     <= 1'b0;
                  cmd_stay    <= 1'b0;
                  cmd_restart <= 1'b0;
                  state       <= LOCKOUT;
               end
            end
            LOCKOUT: begin
               cnt <= lock_next;
               if ((lock_next == LOCK_LAST) && i_HitDeb && i_StayDeb) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_CmdValid   = (state == PENDING);
   assign o_Busy       = (state != IDLE);
   assign o_CmdHit     = cmd_hit;
   assign o_CmdStay    = cmd_stay;
   assign o_CmdRestart = cmd_restart;

endmodule

`default_nettype wire

// File: tb/tb_player_input_ctrl.sv
// tb_player_input_ctrl: directed self-checking bench for player_input_ctrl
// with HOLD_CYCLES=8 and LOCKOUT_CYCLES=4.
`default_nettype none

module tb_player_input_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic hit_deb = 1'b1;
   logic hit_down = 1'b0;
   logic stay_deb = 1'b1;
   logic stay_down = 1'b0;
   logic ack = 1'b0;
   logic cmd_valid, cmd_hit, cmd_stay, cmd_restart, busy;
   logic [4:0] outs;

   int checks = 0;
   int errors = 0;

   // Output vector order: {valid, hit, stay, restart, busy}
   localparam logic [4:0] O_IDLE    = 5'b00000;
   localparam logic [4:0] O_BUSY    = 5'b00001;
   localparam logic [4:0] O_HIT     = 5'b11001;
   localparam logic [4:0] O_STAY    = 5'b10101;
   localparam logic [4:0] O_RESTART = 5'b10011;

   player_input_ctrl #(
      .HOLD_CYCLES   (8),
      .LOCKOUT_CYCLES(4)
   ) dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .i_HitDeb    (hit_deb),
      .i_HitDown   (hit_down),
      .i_StayDeb   (stay_deb),
      .i_StayDown  (stay_down),
      .i_CmdAck    (ack),
      .o_CmdValid  (cmd_valid),
      .o_CmdHit    (cmd_hit),
      .o_CmdStay   (cmd_stay),
      .o_CmdRestart(cmd_restart),
      .o_Busy      (busy)
   );

   assign outs = {cmd_valid, cmd_hit, cmd_stay, cmd_restart, busy};

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_and_drain();
      ack = 1'b1;
      step();
      ack = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %b expected %b", i, outs, O_IDLE);
         end
         step();
      end
   endtask

   task automatic test_hit();
      hit_down = 1'b1; hit_deb = 1'b0;
      step();
      hit_down = 1'b0;
      checks++;
      if (outs !== O_HIT) begin
         errors++; $display("FAIL hit_latch: got %b expected %b", outs, O_HIT);
      end
      hit_deb = 1'b1;
      repeat (3) step();
      checks++;
      if (outs !== O_HIT) begin
         errors++; $display("FAIL hit_held: got %b expected %b", outs, O_HIT);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if (outs !== O_BUSY) begin
         errors++; $display("FAIL hit_ack: got %b expected %b", outs, O_BUSY);
      end
      step();
      hit_down = 1'b1; hit_deb = 1'b0;
      step();
      hit_down = 1'b0; hit_deb = 1'b1;
      checks++;
      if (outs !== O_BUSY) begin
         errors++; $display("FAIL hit_lockout_ignore: got %b expected %b", outs, O_BUSY);
      end
      step();
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL hit_lockout_exit: got %b expected %b", outs, O_IDLE);
      end
      hit_down = 1'b1; hit_deb = 1'b0;
      step();
      hit_down = 1'b0; hit_deb = 1'b1;
      checks++;
      if (outs !== O_HIT) begin
         errors++; $display("FAIL hit_again: got %b expected %b", outs, O_HIT);
      end
      ack_and_drain();
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL hit_drain: got %b expected %b", outs, O_IDLE);
      end
   endtask

   task automatic test_stay_restart();
      stay_down = 1'b1; stay_deb = 1'b0;
      step();
      stay_down = 1'b0;
      step();
      step();
      checks++;
      if (outs !== O_BUSY) begin
         errors++; $display("FAIL stay_holding: got %b expected %b", outs, O_BUSY);
      end
      stay_deb = 1'b1;
      step();
      checks++;
      if (outs !== O_STAY) begin
         errors++; $display("FAIL stay_cmd: got %b expected %b", outs, O_STAY);
      end
      ack_and_drain();
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL stay_drain: got %b expected %b", outs, O_IDLE);
      end
      stay_down = 1'b1; stay_deb = 1'b0;
      step();
      stay_down = 1'b0;
      repeat (7) step();
      checks++;
      if (outs !== O_BUSY) begin
         errors++; $display("FAIL restart_early: got %b expected %b", outs, O_BUSY);
      end
      step();
      checks++;
      if (outs !== O_RESTART) begin
         errors++; $display("FAIL restart_cmd: got %b expected %b", outs, O_RESTART);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      stay_down = 1'b1;
      step();
      stay_down = 1'b0;
      repeat (4) step();
      checks++;
      if (outs !== O_BUSY) begin
         errors++; $display("FAIL restart_no_retrigger: got %b expected %b", outs, O_BUSY);
      end
      stay_deb = 1'b1;
      step();
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL restart_release_exit: got %b expected %b", outs, O_IDLE);
      end
      hit_down = 1'b1; hit_deb = 1'b0;
      step();
      hit_down = 1'b0; hit_deb = 1'b1;
      checks++;
      if (outs !== O_HIT) begin
         errors++; $display("FAIL restart_next_cmd: got %b expected %b", outs, O_HIT);
      end
      ack_and_drain();
   endtask

   task automatic test_both_pulses();
      hit_down = 1'b1; stay_down = 1'b1; hit_deb = 1'b0; stay_deb = 1'b0;
      step();
      hit_down = 1'b0; stay_down = 1'b0; hit_deb = 1'b1; stay_deb = 1'b1;
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL both_pulses: got %b expected %b", outs, O_IDLE);
      end
      step();
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL both_pulses_after: got %b expected %b", outs, O_IDLE);
      end
   endtask

   task automatic test_release_boundary();
      stay_down = 1'b1; stay_deb = 1'b0;
      step();
      stay_down = 1'b0;
      repeat (7) step();
      stay_deb = 1'b1;
      step();
      checks++;
      if (outs !== O_STAY) begin
         errors++; $display("FAIL release_boundary: got %b expected %b", outs, O_STAY);
      end
      ack_and_drain();
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL release_boundary_drain: got %b expected %b", outs, O_IDLE);
      end
   endtask

   task automatic test_reset_mid();
      stay_down = 1'b1; stay_deb = 1'b0;
      step();
      stay_down = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL reset_in_hold: got %b expected %b", outs, O_IDLE);
      end
      stay_deb = 1'b1;
      step();
      hit_down = 1'b1; hit_deb = 1'b0;
      step();
      hit_down = 1'b0; hit_deb = 1'b1;
      checks++;
      if (outs !== O_HIT) begin
         errors++; $display("FAIL reset_pre_pending: got %b expected %b", outs, O_HIT);
      end
      rst = 1'b1; ack = 1'b1;
      step();
      rst = 1'b0; ack = 1'b0;
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL reset_in_pending: got %b expected %b", outs, O_IDLE);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL stray_ack: got %b expected %b", outs, O_IDLE);
      end
      step();
      checks++;
      if (outs !== O_IDLE) begin
         errors++; $display("FAIL stray_ack_after: got %b expected %b", outs, O_IDLE);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_hit();
      test_stay_restart();
      test_both_pulses();
      test_release_boundary();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
